// File: rtl/feed_pkg.sv
// ---------------------------------------------------------------------------
// feed_pkg
// Shared definitions for the skew feed buffer:
//   - feed_state_e : drain sequencer states (IDLE, DRAIN)
//   - last_step()  : index of the final drain step for a given DEPTH/ROWS
//   - cnt_w()      : width of a per-row fill count, $clog2(DEPTH+1)
//   - step_w()     : width of the drain step counter, $clog2(LAST+1)
//   - idx_w()      : width of a row storage index
// Configuration macro: FEED_SKEW_EN selects the diagonally skewed drain.
// ---------------------------------------------------------------------------
package feed_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } feed_state_e;

`ifdef FEED_SKEW_EN
    localparam bit SKEW_EN = 1'b1;
`else
    localparam bit SKEW_EN = 1'b0;
`endif

    // With skew, row ROWS-1 starts ROWS-1 steps late, stretching the drain.
    function automatic int last_step(input int depth, input int rows);
        return SKEW_EN ? (depth + rows - 2) : (depth - 1);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A single-step drain would give a zero-width counter; keep at least 1 bit.
    function automatic int step_w(input int depth, input int rows);
        int w;
        w = $clog2(last_step(depth, rows) + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/feed_row.sv
// ---------------------------------------------------------------------------
// feed_row
// One row queue: DEPTH-entry storage, fill count, append, indexed read and
// full flag.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   push           append data at index count (ignored when full)
//   data           word to append
//   clear          empty the row (count back to 0)
//   rd_idx         combinational read index
//   rd_data        storage word at rd_idx
//   count          number of valid entries (0..DEPTH)
//   full           count == DEPTH
// ---------------------------------------------------------------------------
module feed_row
    import feed_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = cnt_w(DEPTH),
    parameter int IDX_W  = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data,
    input  logic              clear,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic              wr_en;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign wr_en   = push && !full;
    assign count   = count_q;
    assign rd_data = mem[rd_idx];

    // NOTE: storage is deliberately not reset; count_q alone decides which
    // entries are meaningful, so stale words are never presented as valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            // count_q < DEPTH here, so the low IDX_W bits address the entry.
            mem[count_q[IDX_W-1:0]] <= data;
        end
    end

    // NOTE: every clocked register uses non-blocking assignment so all flops
    // sample pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (wr_en) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/skew_feed_buffer.sv
// ---------------------------------------------------------------------------
// skew_feed_buffer
// Collects operand words into ROWS queues of DEPTH entries, then drains all
// rows in parallel towards the MAC array. With FEED_SKEW_EN defined, row r is
// delayed by r steps (diagonal skew); otherwise all rows drain aligned.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   load_valid     load request; accepted when load_ready is high
//   load_ready     high in IDLE (registered state only)
//   load_sel       multi-hot row select, bit 0 = row 0
//   load_data      word appended to every selected row
//   start          drain request, acted on in IDLE only
//   stall          freezes the drain while high
//   result         registered row outputs, row r at [r*DATA_W +: DATA_W]
//   out_valid      per-row valid for result
//   busy           high in DRAIN
//   done           one-cycle pulse with the last drain step
//   overflow       one-cycle pulse after a load hit a full selected row
// Configuration macro: FEED_SKEW_EN.
// ---------------------------------------------------------------------------
`ifndef MM_HGT
`define MM_HGT 4
`endif
`ifndef MM_WDT
`define MM_WDT 4
`endif

module skew_feed_buffer
    import feed_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROWS   = `MM_HGT,
    parameter int DEPTH  = `MM_WDT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [ROWS-1:0]        load_sel,
    input  logic [DATA_W-1:0]      load_data,
    input  logic                   start,
    input  logic                   stall,
    output logic [ROWS*DATA_W-1:0] result,
    output logic [ROWS-1:0]        out_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int LAST   = last_step(DEPTH, ROWS);
    localparam int CNT_W  = cnt_w(DEPTH);
    localparam int STEP_W = step_w(DEPTH, ROWS);
    localparam int IDX_W  = idx_w(DEPTH);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(LAST);

    feed_state_e       state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              drain_en;
    logic              last_hit;
    logic              load_fire;

    logic [ROWS-1:0]        push;
    logic [ROWS-1:0]        ovf_hit;
    logic [ROWS-1:0]        full;
    logic [ROWS-1:0]        hit;
    logic [DATA_W-1:0]      word [ROWS];
    logic [ROWS*DATA_W-1:0] step_flat;

    logic [ROWS*DATA_W-1:0] result_q;
    logic [ROWS-1:0]        out_valid_q;
    logic                   done_q;
    logic                   overflow_q;

    assign load_ready = (state_q == IDLE);
    assign load_fire  = load_valid && load_ready;
    assign busy       = (state_q == DRAIN);
    assign result     = result_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [CNT_W-1:0]  count_r;
        logic [IDX_W-1:0]  rd_idx_r;
        logic [DATA_W-1:0] rd_data_r;
        logic              hit_r;
        int                k;

        // k is the entry this row presents at the current step; negative or
        // past the fill count means the row is idle for this step.
        always_comb begin
`ifdef FEED_SKEW_EN
            k = int'(step_q) - r;
`else
            k = int'(step_q);
`endif
            hit_r    = (k >= 0) && (k < int'(count_r));
            rd_idx_r = k[IDX_W-1:0];
        end

        assign push[r]    = load_fire && load_sel[r] && !full[r];
        assign ovf_hit[r] = load_fire && load_sel[r] && full[r];
        assign hit[r]     = hit_r;
        assign word[r]    = hit_r ? rd_data_r : '0;

        feed_row #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W),
            .IDX_W  (IDX_W)
        ) u_row (
            .clk     (clk),
            .reset   (reset),
            .push    (push[r]),
            .data    (load_data),
            .clear   (last_hit),
            .rd_idx  (rd_idx_r),
            .rd_data (rd_data_r),
            .count   (count_r),
            .full    (full[r])
        );
    end

    always_comb begin
        step_flat = '0;
        for (int r = 0; r < ROWS; r++) begin
            step_flat[r*DATA_W +: DATA_W] = word[r];
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        drain_en = 1'b0;
        last_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRAIN;
                    step_d  = '0;
                end
            end
            DRAIN: begin
                if (!stall) begin
                    drain_en = 1'b1;
                    if (step_q == LAST_STEP) begin
                        last_hit = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            out_valid_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q     <= last_hit;
            overflow_q <= |ovf_hit;
            if (drain_en) begin
                result_q    <= step_flat;
                out_valid_q <= hit;
            end else if (state_q == IDLE) begin
                // Clears the final step one cycle after done; stays zero in IDLE.
                result_q    <= '0;
                out_valid_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_skew_feed_buffer.sv
// ---------------------------------------------------------------------------
// tb_skew_feed_buffer
// Scoreboard bench for skew_feed_buffer (DATA_W=32, ROWS=4, DEPTH=4). The
// stimulus side keeps plain queues per row, and at each start it expands them
// into the full list of expected drain steps. A monitor pops one entry per
// unstalled drain edge and compares; stalled cycles must repeat the last
// entry and idle cycles must show zeros.
// Follows FEED_SKEW_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_skew_feed_buffer;

    localparam int DATA_W = 32;
    localparam int ROWS   = 4;
    localparam int DEPTH  = 4;
    localparam int OUT_W  = ROWS * DATA_W;
`ifdef FEED_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif
    localparam int LAST = SKEW ? (DEPTH + ROWS - 2) : (DEPTH - 1);

    logic              clk;
    logic              reset;
    logic              load_valid;
    logic              load_ready;
    logic [ROWS-1:0]   load_sel;
    logic [DATA_W-1:0] load_data;
    logic              start;
    logic              stall;
    logic [OUT_W-1:0]  result;
    logic [ROWS-1:0]   out_valid;
    logic              busy;
    logic              done;
    logic              overflow;

    skew_feed_buffer #(
        .DATA_W (DATA_W),
        .ROWS   (ROWS),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_sel   (load_sel),
        .load_data  (load_data),
        .start      (start),
        .stall      (stall),
        .result     (result),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] res;
        logic [ROWS-1:0]  vld;
        logic             dn;
    } exp_t;

    exp_t              sb [$];
    logic [DATA_W-1:0] model [ROWS][$];
    int                n_cmp = 0;
    int                n_bad = 0;

    task automatic check(input string name, input logic [OUT_W-1:0] act,
                         input logic [OUT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rules: a selected row accepts the word while it holds fewer
    // than DEPTH words; otherwise the word is lost and overflow is expected.
    task automatic model_load(input logic [ROWS-1:0] sel, input logic [DATA_W-1:0] d,
                              output bit ovf);
        ovf = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (sel[r]) begin
                if (model[r].size() < DEPTH) model[r].push_back(d);
                else                         ovf = 1'b1;
            end
        end
    endtask

    // Step s shows row r's word number s-r (skew) or s, when it exists.
    task automatic model_drain_push();
        for (int s = 0; s <= LAST; s++) begin
            exp_t e;
            e.res = '0;
            e.vld = '0;
            e.dn  = (s == LAST);
            for (int r = 0; r < ROWS; r++) begin
                int k;
                k = SKEW ? (s - r) : s;
                if (k >= 0 && k < model[r].size()) begin
                    e.vld[r] = 1'b1;
                    e.res[r*DATA_W +: DATA_W] = model[r][k];
                end
            end
            sb.push_back(e);
        end
        for (int r = 0; r < ROWS; r++) model[r].delete();
    endtask

    // Monitor: decides at each falling edge what the coming rising edge does.
    initial begin
        bit   step_flag;
        bit   stall_flag;
        exp_t e;
        exp_t last_e;
        step_flag  = 1'b0;
        stall_flag = 1'b0;
        last_e.res = '0;
        last_e.vld = '0;
        last_e.dn  = 1'b0;
        forever begin
            @(negedge clk);
            if (step_flag) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_empty: got drain step expected none (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("step_result", result, e.res);
                    check("step_valid", OUT_W'(out_valid), OUT_W'(e.vld));
                    check("step_done", OUT_W'(done), OUT_W'(e.dn));
                    last_e = e;
                end
            end else if (stall_flag) begin
                check("stall_result", result, last_e.res);
                check("stall_valid", OUT_W'(out_valid), OUT_W'(last_e.vld));
                check("stall_done", OUT_W'(done), OUT_W'(last_e.dn));
            end else begin
                check("idle_result", result, '0);
                check("idle_valid", OUT_W'(out_valid), '0);
                check("idle_done", OUT_W'(done), '0);
                last_e.res = '0;
                last_e.vld = '0;
                last_e.dn  = 1'b0;
            end
            check("busy", OUT_W'(busy), OUT_W'(sb.size() > 0));
            check("load_ready", OUT_W'(load_ready), OUT_W'(sb.size() == 0));
            step_flag  = (busy === 1'b1) && !stall && !reset;
            stall_flag = (busy === 1'b1) && stall && !reset;
        end
    end

    task automatic do_load(input logic [ROWS-1:0] sel, input logic [DATA_W-1:0] d);
        bit ovf;
        model_load(sel, d, ovf);
        load_valid = 1'b1;
        load_sel   = sel;
        load_data  = d;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        check("overflow", OUT_W'(overflow), OUT_W'(ovf));
    endtask

    // Issues start (optionally with a same-edge load) and waits for the drain.
    // Stall is forced for stall_len cycles from stall_at and randomly at pct%.
    task automatic do_drain(input bit with_load, input logic [ROWS-1:0] sel,
                            input logic [DATA_W-1:0] d, input int stall_at,
                            input int stall_len, input int pct);
        bit ovf;
        int c;
        ovf = 1'b0;
        if (with_load) begin
            model_load(sel, d, ovf);
            load_valid = 1'b1;
            load_sel   = sel;
            load_data  = d;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        load_valid = 1'b0;
        if (with_load) check("start_load_overflow", OUT_W'(overflow), OUT_W'(ovf));
        model_drain_push();
        c = 0;
        while (sb.size() > 0 && c < 200) begin
            stall = (c >= stall_at && c < stall_at + stall_len) ||
                    (int'($urandom_range(99)) < pct);
            @(posedge clk);
            #1;
            c++;
        end
        stall = 1'b0;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d steps pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_sel   = '0;
        load_data  = '0;
        start      = 1'b0;
        stall      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_result", result, '0);
        check("reset_valid", OUT_W'(out_valid), '0);
        check("reset_done", OUT_W'(done), '0);
        check("reset_overflow", OUT_W'(overflow), '0);
        check("reset_busy", OUT_W'(busy), '0);

        // Rows 0 and 1 partially loaded.
        for (int i = 0; i < 4; i++) do_load(4'b0001, DATA_W'(32'h10 + i));
        for (int i = 0; i < 4; i++) do_load(4'b0010, DATA_W'(32'h20 + i));
        do_drain(1'b0, '0, '0, -1, 0, 0);

        // Multi-hot load: one word into every row.
        do_load(4'b1111, 32'hAA);
        do_drain(1'b0, '0, '0, -1, 0, 0);

        // Fifth load into a full row is dropped and flagged.
        for (int i = 1; i <= 5; i++) do_load(4'b0100, DATA_W'(i));
        do_drain(1'b0, '0, '0, -1, 0, 0);

        // Stall for three cycles while step 2 is on the outputs.
        for (int i = 0; i < 4; i++) do_load(4'b1111, DATA_W'(32'h40 + i));
        do_drain(1'b0, '0, '0, 3, 3, 0);

        // Reset while step 1 is on the outputs.
        do_load(4'b1001, 32'h55);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_drain_push();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        check("rst_mid_load_ready", OUT_W'(load_ready), OUT_W'(1));
        check("rst_mid_valid", OUT_W'(out_valid), '0);
        check("rst_mid_done", OUT_W'(done), '0);
        do_drain(1'b0, '0, '0, -1, 0, 0);

        // Load on the same edge as start joins the drain.
        do_load(4'b0011, 32'h77);
        do_drain(1'b1, 4'b0110, 32'h88, -1, 0, 0);

        // Randomised loads and stalls.
        for (int it = 0; it < 20; it++) begin
            int n;
            n = int'($urandom_range(7));
            for (int i = 0; i < n; i++) do_load(ROWS'($urandom), $urandom);
            do_drain(($urandom_range(1) == 1), ROWS'($urandom), $urandom, -1, 0, 25);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/skew_feed_buffer.md
# skew_feed_buffer

Parametrised row-buffer that collects operand words into ROWS independent queues of up to DEPTH entries each, then drains all rows in parallel into the systolic multiply array, optionally skewed diagonally so row r starts r cycles after row 0. It replaces the fixed 32-bit shift-array feeder. It adds valid/ready loading, per-row fill counts, a start/done drain sequence, stall support, and overflow reporting. It sits between the AXI-Lite register front end and the MAC array inside the accelerator IP.

## Interface
- DATA_W, 32, operand word width in bits
- ROWS, `MM_HGT, number of row queues (≥1)
- DEPTH, `MM_WDT, entries per row queue (≥1)
- clk  in  1  clock; all logic is rising-edge
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  load request
- load_ready  out  1  high when the block is in IDLE
- load_sel  in  ROWS  multi-hot row select; bit 0 is row 0
- load_data  in  DATA_W  word appended to every selected row
- start  in  1  drain request; acted on only in IDLE
- stall  in  1  freezes the drain while high
- result  out  ROWS*DATA_W  registered row outputs; row r is at bits [r*DATA_W +: DATA_W]
- out_valid  out  ROWS  per-row valid for result
- busy  out  1  high in DRAIN
- done  out  1  one-cycle pulse coinciding with the last drain step
- overflow  out  1  one-cycle pulse when a load hits a full selected row

## Operation
- States: IDLE, DRAIN.
- Reset values: state=IDLE, all counts=0, result=0, out_valid=0, busy=0, done=0, overflow=0. Storage contents need not be cleared.
- Load handshake:
  - A load is accepted on any edge where load_valid && load_ready.
  - Each selected row with count[r]<DEPTH stores load_data at index count[r] and increments count[r].
  - A selected row with count[r]==DEPTH drops the word, and overflow pulses on the next cycle.
  - Unselected rows are unchanged. load_sel=0 is accepted and has no effect.
- Drain:
  - start in IDLE moves the block to DRAIN with step counter t=0.
  - LAST = DEPTH+ROWS-2 (skew) or DEPTH-1 (no skew).
  - At each DRAIN edge with stall low: for each row r, with k=t-r (skew) or k=t (no skew), set result[r]=mem[r][k] and out_valid[r]=1 if 0≤k<count[r]; otherwise result[r]=0 and out_valid[r]=0. Then t increments.
  - On the edge that loads step LAST: done=1, state goes to IDLE, and all counts clear.
  - On the following edge: result=0, out_valid=0, done=0.
- Stall: holds t, result, out_valid and state. A stall on the LAST-step edge delays done by the same amount.
- start in DRAIN is ignored. load_valid in DRAIN is not accepted because load_ready is low.
- Simultaneous load and start in IDLE: both are taken. The loaded word is part of the drain.
- start with all counts 0: the full LAST+1-step drain still runs, with out_valid all 0. done pulses normally.
- reset mid-drain: on the reset edge the block returns to IDLE with reset values. The drain is abandoned and no done is issued.

## Timing
- start is sampled at edge k. Step 0 appears on the outputs after edge k+1. Step s appears after edge k+1+s (no stalls).
- done is high during the cycle that shows step LAST, i.e. the cycle after edge k+1+LAST.
- busy is high from edge k until the edge that loads step LAST.
- A load sampled at edge j is visible to a drain started at edge j or later.
- load_ready is derived only from registered state and has no input-to-output combinational path.

## Configuration
- FEED_SKEW_EN defined: diagonal skew applies. Row r lags row 0 by r steps, and the drain takes DEPTH+ROWS-1 steps.
- FEED_SKEW_EN undefined: all rows are aligned (k=t), and the drain takes DEPTH steps. The skew subtractors are not built.

## Structure
- Shared package feed_pkg holds:
  - the state enum (IDLE, DRAIN);
  - a constant function for LAST(DEPTH, ROWS);
  - the width helpers CNT_W=$clog2(DEPTH+1) and STEP_W=$clog2(LAST+1).
- Sub-module feed_row: one queue with storage, count, append, indexed read and full flag. It is instantiated ROWS times in a generate loop. The top level holds the FSM, the step counter and the output registers.

## Test plan
- Loading and draining (DATA_W=32, ROWS=4, DEPTH=4, skew):
  - Stimulus: load 0x10–0x13 to row 0 and 0x20–0x23 to row 1, then start.
  - Required response: row 0 outputs 0x10..0x13 at steps 0–3. Row 1 outputs 0x20..0x23 at steps 1–4. Rows 2 and 3 have out_valid=0 throughout. done is high at step 6.
- Multi-hot load: load_sel=4'b1111 with data 0xAA, then start. Each row emits 0xAA exactly once, at step r.
- Overflow: five loads of 1..5 to row 2, with DEPTH=4. overflow pulses after the fifth load. The drain shows 1..4 only.
- Stall: stall held for 3 cycles at step 2. result and out_valid are frozen, and done arrives 3 cycles later than in the unstalled case.
- Reset mid-drain: reset asserted at step 1. The next cycle shows out_valid=0, done=0 and load_ready=1. A new start with no loads runs a full drain with out_valid all 0.
- Non-skew build (FEED_SKEW_EN undefined): all four rows loaded, then start. All rows are valid at steps 0–3 together, and done is high at step 3.
